// File: rtl/mdu_iter.sv
// Multi-cycle unsigned multiply/divide unit: shift-add multiply and restoring
// division, one bit per cycle, with valid/ready request and result handshakes.
module mdu_iter #(
   parameter int unsigned REG_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [1:0]           i_op,
   input  logic [REG_WIDTH-1:0] first_op,
   input  logic [REG_WIDTH-1:0] second_op,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [REG_WIDTH-1:0] o_data,
   output logic                 o_div_zero
);

   localparam int unsigned W     = REG_WIDTH;
   localparam int unsigned CNT_W = $clog2(REG_WIDTH) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [1:0] OP_MUL_H = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;

   logic [1:0]       state_q, state_d;
   logic [1:0]       op_q;
   logic [W-1:0]     a_q;       // multiplicand, or dividend shifting into quotient
   logic [W-1:0]     b_q;       // multiplier shifting right, or divisor
   logic [2*W-1:0]   prod_q;
   logic [W-1:0]     rem_q;
   logic [CNT_W-1:0] cnt_q;
   logic             dz_q;

   logic             last_iter_c;
   logic [W-1:0]     addend_c;
   logic [W:0]       add_c;
   logic [2*W-1:0]   prod_next_c;
   logic [W:0]       shifted_c;
   logic [W:0]       diff_c;
   logic             no_borrow_c;
   logic [W-1:0]     rem_next_c;
   logic [W-1:0]     quot_next_c;

   assign o_ready     = (state_q == S_IDLE);
   assign last_iter_c = (cnt_q == CNT_W'(W - 1));

   // Multiply step: add multiplicand into the upper half, then shift right.
   assign addend_c    = b_q[0] ? a_q : '0;
   assign add_c       = {1'b0, prod_q[2*W-1:W]} + {1'b0, addend_c};
   assign prod_next_c = (2*W)'({add_c, prod_q[W-1:0]} >> 1);

   // Restoring divide step; the partial remainder is always below the divisor,
   // so bit W of the difference is exactly the borrow.
   assign shifted_c   = {rem_q, a_q[W-1]};
   assign diff_c      = shifted_c - {1'b0, b_q};
   assign no_borrow_c = ~diff_c[W];
   assign rem_next_c  = no_borrow_c ? diff_c[W-1:0] : shifted_c[W-1:0];
   assign quot_next_c = {a_q[W-2:0], no_borrow_c};

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (i_valid) state_d = i_op[1] ? S_DIV : S_MUL;
         S_MUL:  if (last_iter_c) state_d = S_DONE;
         S_DIV:  if (dz_q || last_iter_c) state_d = S_DONE;
         S_DONE: if (i_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         prod_q     <= '0;
         rem_q      <= '0;
         cnt_q      <= '0;
         dz_q       <= 1'b0;
         o_valid    <= 1'b0;
         o_data     <= '0;
         o_div_zero <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_valid) begin
                  op_q   <= i_op;
                  a_q    <= first_op;
                  b_q    <= second_op;
                  prod_q <= '0;
                  rem_q  <= '0;
                  cnt_q  <= '0;
                  dz_q   <= i_op[1] && (second_op == '0);
               end
            end
            S_MUL: begin
               prod_q <= prod_next_c;
               b_q    <= b_q >> 1;
               if (last_iter_c) begin
                  o_valid    <= 1'b1;
                  o_div_zero <= 1'b0;
                  o_data     <= (op_q == OP_MUL_H) ? prod_next_c[2*W-1:W]
                                                   : prod_next_c[W-1:0];
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_DIV: begin
               if (dz_q) begin
                  o_valid    <= 1'b1;
                  o_div_zero <= 1'b1;
                  o_data     <= (op_q == OP_DIV) ? '1 : a_q;
               end else begin
                  rem_q <= rem_next_c;
                  a_q   <= quot_next_c;
                  if (last_iter_c) begin
                     o_valid    <= 1'b1;
                     o_div_zero <= 1'b0;
                     o_data     <= (op_q == OP_DIV) ? quot_next_c : rem_next_c;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            S_DONE: begin
               if (i_ready) begin
                  o_valid    <= 1'b0;
                  o_div_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
